clock_div_prog: RTL and testbench

- Runtime-programmable integer clock divider; next generation of the fixed divide-by-5 block.
- Generates a divided clock with exact 50% duty for odd and even divisors, plus a programmable-duty mode and a one-cycle period tick.
- New divisor, duty and mode values arrive over a valid/ready config port and take effect only on a period boundary, so the output never glitches.
- Sits between the board clock and downstream blocks that need slower clocks or clock enables.

---
 rtl/clk_div_pkg.sv | 30 +++
 rtl/clock_div_prog_if.sv | 16 +
 rtl/clk_div_core.sv | 60 ++++++
 rtl/clock_div_prog.sv | 97 +++++++++
 tb/tb_clock_div_prog.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CFG_W   = 8;
  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    MODE_HALF = 1'b0,
    MODE_DUTY = 1'b1
  } mode_e;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] duty;
    mode_e            mode;
  } cfg_t;

  // Keep the high count strictly inside the period so both levels always appear.
  function automatic logic [CFG_W-1:0] clamp_duty(input logic [CFG_W-1:0] div,
                                                  input logic [CFG_W-1:0] duty);
    logic [CFG_W-1:0] r;
    r = duty;
    if (duty == '0)
      r = CFG_W'(1);
    else if (duty >= div)
      r = div - CFG_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/clock_div_prog_if.sv
// Configuration request port of the programmable clock divider.
interface clock_div_prog_if #(
  parameter int unsigned W = 8
) ();
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_duty;
  logic         cfg_mode;
  logic         cfg_err;

  modport master (output cfg_valid, cfg_div, cfg_duty, cfg_mode,
                  input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_div, cfg_duty, cfg_mode,
                  output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_core.sv
// Period counter, posedge/negedge waveform flops and output select for one active config.
module clk_div_core
  import clk_div_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  cfg_t cfg_i,
  output logic last_o,
  output logic tick_o,
  output logic clk_pos_o,
  output logic clk_neg_o,
  output logic clk_out_o
);

  localparam int unsigned HW = CFG_W + 1;

  logic [CFG_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    high;
  logic             last;
  logic             pos_q, pos_d;
  logic             tick_q;
  logic             neg_q;

  always_comb begin
    last  = (cnt_q == cfg_i.div - CFG_W'(1));
    cnt_d = last ? '0 : cnt_q + CFG_W'(1);
    if (cfg_i.mode == MODE_DUTY)
      high = {1'b0, cfg_i.duty};
    else
      high = ({1'b0, cfg_i.div} + HW'(1)) >> 1;
    pos_d = ({1'b0, cnt_q} < high);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      tick_q <= last;
    end
  end

  always_ff @(negedge clk_in) begin
    if (!rst_n)
      neg_q <= 1'b0;
    else
      neg_q <= pos_q;
  end

  // Odd 50% mode trims half a cycle off the posedge waveform's extra high cycle.
  assign clk_out_o = (cfg_i.mode == MODE_HALF && cfg_i.div[0]) ? (pos_q & neg_q) : pos_q;
  assign last_o    = last;
  assign tick_o    = tick_q;
  assign clk_pos_o = pos_q;
  assign clk_neg_o = neg_q;

endmodule

// File: rtl/clock_div_prog.sv
// Programmable clock divider: config handshake, pending register and boundary-aligned update.
module clock_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned W            = CFG_W,
  parameter int unsigned DEFAULT_DIV  = 5,
  parameter int unsigned DEFAULT_DUTY = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  clock_div_prog_if.slave        cfg,
  output logic                   clk_pos,
  output logic                   clk_neg,
  output logic                   clk_out,
  output logic                   tick
);

  localparam cfg_t CFG_RESET = '{div:  CFG_W'(DEFAULT_DIV),
                                 duty: CFG_W'(DEFAULT_DUTY),
                                 mode: MODE_HALF};

  logic [W-1:0] req_div_w, req_duty_w;
  cfg_t         req;
  cfg_t         act_q, act_d;
  cfg_t         pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         ready_q, ready_d;
  logic         err_q, err_d;
  logic         last;
  logic         accept, legal;

  assign req_div_w  = cfg.cfg_div;
  assign req_duty_w = cfg.cfg_duty;

  always_comb begin
    req.div  = CFG_W'(req_div_w);
    req.mode = mode_e'(cfg.cfg_mode);
    req.duty = CFG_W'(req_duty_w);
    if (req.mode == MODE_DUTY)
      req.duty = clamp_duty(req.div, CFG_W'(req_duty_w));
  end

  assign accept = cfg.cfg_valid && ready_q;
  assign legal  = (req.div >= CFG_W'(MIN_DIV));

  // Ready is low exactly while a request waits, so an accept never collides with a load.
  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = 1'b0;
    if (last && pend_vld_q) begin
      act_d      = pend_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      if (legal) begin
        pend_d     = req;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    ready_d = !pend_vld_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      act_q      <= CFG_RESET;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  clk_div_core u_core (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_i     (act_q),
    .last_o    (last),
    .tick_o    (tick),
    .clk_pos_o (clk_pos),
    .clk_neg_o (clk_neg),
    .clk_out_o (clk_out)
  );

endmodule

// File: tb/tb_clock_div_prog.sv
// Scoreboard bench for clock_div_prog against a period-level reference model.
module tb_clock_div_prog;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic clk_pos, clk_neg, clk_out, tick;

  clock_div_prog_if #(.W(8)) cfg_if ();

  clock_div_prog #(.W(8), .DEFAULT_DIV(5), .DEFAULT_DUTY(2)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .cfg     (cfg_if),
    .clk_pos (clk_pos),
    .clk_neg (clk_neg),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Expected outputs for one input cycle: first-half values after posedge.
  typedef struct {
    bit chk;
    bit tick, pos, ready, err, neg1, out1;
  } exp_t;

  exp_t sb[$];

  // Reference model: whole periods are generated from the active config as a list of levels.
  bit          m_per[$];
  int unsigned a_div, a_duty, p_div, p_duty;
  bit          a_mode, p_mode, pend, m_ready, prev_pos, odd_half;
  bit          first = 1'b1;

  initial begin
    exp_t        e;
    int unsigned high, dd, dv;
    bit          p;
    a_div = 5; a_duty = 2; a_mode = 0; pend = 0; m_ready = 0; prev_pos = 0; odd_half = 1;
    forever begin
      @(posedge clk_in);
      e       = '{default: 0};
      e.chk   = !first;
      first   = 1'b0;
      e.neg1  = prev_pos;
      if (!rst_n) begin
        a_div = 5; a_duty = 2; a_mode = 0;
        pend = 0; m_ready = 0; prev_pos = 0;
        m_per.delete();
      end else begin
        if (m_per.size() == 0) begin
          high     = a_mode ? a_duty : (a_div + 1) / 2;
          odd_half = !a_mode && (a_div % 2 == 1);
          for (int unsigned c = 0; c < a_div; c++) m_per.push_back(c < high);
        end
        p      = m_per.pop_front();
        e.pos  = p;
        e.tick = (m_per.size() == 0);
        e.out1 = odd_half ? (p & prev_pos) : p;
        if (e.tick && pend) begin
          a_div = p_div; a_duty = p_duty; a_mode = p_mode; pend = 0;
        end
        if (cfg_if.cfg_valid && m_ready) begin
          dv = cfg_if.cfg_div;
          dd = cfg_if.cfg_duty;
          if (dv < 2) e.err = 1;
          else begin
            if (cfg_if.cfg_mode) begin
              if (dd == 0) dd = 1;
              else if (dd >= dv) dd = dv - 1;
            end
            pend = 1; p_div = dv; p_duty = dd; p_mode = cfg_if.cfg_mode;
          end
        end
        m_ready  = !pend;
        prev_pos = p;
      end
      e.ready = m_ready;
      sb.push_back(e);
    end
  end

  // Monitor: pops one expectation per cycle, checks both half-cycles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      chk("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          chk("tick",      tick,             e.tick);
          chk("clk_pos",   clk_pos,          e.pos);
          chk("clk_neg_h1", clk_neg,         e.neg1);
          chk("clk_out_h1", clk_out,         e.out1);
          chk("cfg_ready", cfg_if.cfg_ready, e.ready);
          chk("cfg_err",   cfg_if.cfg_err,   e.err);
        end
        @(negedge clk_in);
        #1;
        if (e.chk) begin
          chk("clk_neg_h2", clk_neg, e.pos);
          chk("clk_out_h2", clk_out, e.pos);
        end
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk_in);
      #2;
    end
  endtask

  task automatic req(input int unsigned d, input int unsigned h, input bit m, input bit wait_rdy);
    int unsigned n;
    logic [31:0] dw, hw;
    dw = d;
    hw = h;
    if (wait_rdy) begin
      n = 0;
      while (cfg_if.cfg_ready !== 1'b1 && n < 200) begin
        @(negedge clk_in);
        #2;
        n++;
      end
      chk("ready_wait_bound", n < 200, 1'b1);
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = dw[7:0];
    cfg_if.cfg_duty  = hw[7:0];
    cfg_if.cfg_mode  = m;
    @(negedge clk_in);
    #2;
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    int unsigned n;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_duty  = '0;
    cfg_if.cfg_mode  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    #2;
    rst_n = 1'b1;
    idle(15);

    req(4, 0, 1'b0, 1'b1); idle(20);
    req(7, 3, 1'b1, 1'b1); idle(25);
    req(7, 9, 1'b1, 1'b1); idle(25);
    req(1, 0, 1'b0, 1'b1); idle(3);
    req(0, 5, 1'b1, 1'b1); idle(20);

    // Request accepted on the last cycle of a period, then a second one while pending.
    n = 0;
    while (!(m_per.size() == 1 && cfg_if.cfg_ready === 1'b1) && n < 100) begin
      idle(1);
      n++;
    end
    chk("boundary_wait_bound", n < 100, 1'b1);
    req(3, 0, 1'b0, 1'b0);
    req(9, 1, 1'b1, 1'b0);
    idle(25);

    for (int unsigned i = 0; i < 40; i++) begin
      idle($urandom_range(0, 15));
      req($urandom_range(0, 12), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 9) == 0) begin
        idle($urandom_range(0, 3));
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
    end

    // Reset while a request is pending.
    req(6, 0, 1'b0, 1'b1);
    idle(1);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(25);

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
